// File: rtl/demux8_dispatch_ctrl_if.sv
// demux8_dispatch_ctrl_if: bundle of the upstream valid/ready source
// and the 8-way demux side of the dispatch controller.
//   in_valid/in_ready/in_data/in_dest/ch_en : upstream word + routing
//   out_valid/out_data/out_ready/sel         : demux side
//   drop_pulse/drop_count/busy               : status
// master = controller view, slave = environment view.
interface demux8_dispatch_ctrl_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2:0]    in_dest;
    logic [7:0]    ch_en;
    logic [7:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [7:0]    out_ready;
    logic [2:0]    sel;
    logic          drop_pulse;
    logic [7:0]    drop_count;
    logic          busy;

    modport master (
        input  in_valid, in_data, in_dest, ch_en, out_ready,
        output in_ready, out_valid, out_data, sel,
        output drop_pulse, drop_count, busy
    );

    modport slave (
        output in_valid, in_data, in_dest, ch_en, out_ready,
        input  in_ready, out_valid, out_data, sel,
        input  drop_pulse, drop_count, busy
    );
endinterface

// File: rtl/demux8_dispatch_ctrl.sv
// demux8_dispatch_ctrl: holds one upstream word and presents it to one of
// eight channels, dropping words for disabled or stalled channels.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : demux8_dispatch_ctrl_if.master (handshakes + status)
module demux8_dispatch_ctrl #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    demux8_dispatch_ctrl_if.master       bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t        state_q;
    logic [7:0]    timer_q;
    logic [7:0]    out_valid_q;
    logic [DW-1:0] out_data_q;
    logic [2:0]    sel_q;
    logic          drop_pulse_q;
    logic [7:0]    drop_count_q;
    logic [7:0]    drop_count_d;

    logic accept;
    logic dest_en;
    logic xfer;
    logic tmo;
    logic drop;

    assign accept  = (state_q == IDLE) && bus.in_valid && rst_n;
    assign dest_en = bus.ch_en[bus.in_dest];
    assign xfer    = bus.out_ready[sel_q];
    assign tmo     = (timer_q == TMO_LAST);

    // Ready on the last timeout cycle wins over the drop.
    assign drop = (accept && !dest_en) ||
                  ((state_q == HOLD) && !xfer && tmo);

    assign drop_count_d = (drop_count_q == 8'hFF) ? drop_count_q
                                                   : drop_count_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            out_valid_q  <= '0;
            out_data_q   <= '0;
            sel_q        <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            drop_pulse_q <= drop;
            if (drop) begin
                drop_count_q <= drop_count_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept && dest_en) begin
                        state_q     <= HOLD;
                        out_data_q  <= bus.in_data;
                        sel_q       <= bus.in_dest;
                        timer_q     <= '0;
                        out_valid_q <= 8'b1 << bus.in_dest;
                    end
                end
                HOLD: begin
                    if (xfer || tmo) begin
                        state_q     <= IDLE;
                        out_valid_q <= '0;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // in_ready depends only on state and reset, never on in_valid.
    assign bus.in_ready   = rst_n && (state_q == IDLE);
    assign bus.busy       = (state_q == HOLD);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.sel        = sel_q;
    assign bus.drop_pulse = drop_pulse_q;
    assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_demux8_dispatch_ctrl.sv
// tb_demux8_dispatch_ctrl: scoreboard bench for demux8_dispatch_ctrl.
// Drives at negedge+1, checks at negedge+1, monitor at negedge+3.
module tb_demux8_dispatch_ctrl;
    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int drops_seen = 0;
    time acc_t;
    logic [10:0] sbq[$];

    demux8_dispatch_ctrl_if #(.DW(8)) bus ();

    demux8_dispatch_ctrl #(.DW(8), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: compares every completed transfer with the scoreboard.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (bus.drop_pulse === 1'b1) drops_seen++;
            if (rst_n && bus.out_valid != 8'h00 &&
                (bus.out_valid & bus.out_ready) != 8'h00) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL xfer_unexpected: sel=%0d data=%h got, none required",
                             bus.sel, bus.out_data);
                end else begin
                    e = sbq.pop_front();
                    if ({bus.sel, bus.out_data} !== e ||
                        bus.out_valid !== (8'b1 << e[10:8])) begin
                        errors++;
                        $display("FAIL xfer_data: sel=%0d data=%h ov=%b got, sel=%0d data=%h required",
                                 bus.sel, bus.out_data, bus.out_valid, e[10:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] d, input logic [7:0] dat,
                        input logic [7:0] en, input bit exp_xfer);
        int n = 0;
        @(negedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_dest  = d;
        bus.in_data  = dat;
        bus.ch_en    = en;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b got, 1 required", bus.in_ready);
        end else begin
            acc_t = $time;
            if (exp_xfer) sbq.push_back({d, dat});
        end
        @(negedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_dest = '0;
        bus.ch_en = 8'hFF;
        bus.out_ready = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.sel,
             bus.drop_pulse, bus.drop_count, bus.busy} !== 30'h0) begin
            errors++;
            $display("FAIL reset_vals: rdy=%b ov=%h od=%h sel=%0d dp=%b dc=%0d busy=%b got, all 0 required",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.sel,
                     bus.drop_pulse, bus.drop_count, bus.busy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b got, 1 required", bus.in_ready);
        end
    endtask

    task automatic test_sweep;
        time prev_t = 0;
        bus.out_ready = 8'hFF;
        for (int d = 0; d < 8; d++) begin
            send(3'(d), 8'hA0 + 8'(d), 8'hFF, 1'b1);
            checks++;
            if (bus.out_valid !== (8'b1 << d) || bus.sel !== 3'(d) ||
                bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL sweep_hold: ov=%b sel=%0d busy=%b got, ov=%b sel=%0d required",
                         bus.out_valid, bus.sel, bus.busy, 8'b1 << d, d);
            end
            if (d > 0) begin
                checks++;
                if (acc_t - prev_t != 20) begin
                    errors++;
                    $display("FAIL back_to_back: spacing=%0t got, 20 required",
                             acc_t - prev_t);
                end
            end
            prev_t = acc_t;
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 8'h00 || bus.drop_count !== 8'd0 ||
            sbq.size() != 0) begin
            errors++;
            $display("FAIL sweep_end: ov=%h dc=%0d pending=%0d got, 0/0/0 required",
                     bus.out_valid, bus.drop_count, sbq.size());
        end
    endtask

    task automatic test_disabled;
        logic [7:0] dc0;
        dc0 = bus.drop_count;
        send(3'd3, 8'h33, 8'hF7, 1'b0);
        checks++;
        if (bus.out_valid !== 8'h00 || bus.busy !== 1'b0 ||
            bus.drop_pulse !== 1'b1 || bus.drop_count !== dc0 + 8'd1) begin
            errors++;
            $display("FAIL disabled_drop: ov=%h busy=%b dp=%b dc=%0d got, 0/0/1/%0d required",
                     bus.out_valid, bus.busy, bus.drop_pulse, bus.drop_count, dc0 + 8'd1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.drop_pulse !== 1'b0) begin
            errors++;
            $display("FAIL disabled_pulse_len: dp=%b got, 0 required", bus.drop_pulse);
        end
        send(3'd2, 8'h52, 8'hF7, 1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0 || bus.drop_count !== dc0 + 8'd1) begin
            errors++;
            $display("FAIL disabled_next: pending=%0d dc=%0d got, 0/%0d required",
                     sbq.size(), bus.drop_count, dc0 + 8'd1);
        end
    endtask

    task automatic test_timeout;
        logic [7:0] dc0;
        int n = 0;
        bus.out_ready = 8'h00;
        dc0 = bus.drop_count;
        send(3'd5, 8'h55, 8'hFF, 1'b0);
        while (bus.out_valid === 8'h20 && n < 300) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL timeout_len: %0d cycles got, 15 required", n);
        end
        checks++;
        if (bus.drop_pulse !== 1'b1 || bus.in_ready !== 1'b1 ||
            bus.drop_count !== dc0 + 8'd1) begin
            errors++;
            $display("FAIL timeout_drop: dp=%b rdy=%b dc=%0d got, 1/1/%0d required",
                     bus.drop_pulse, bus.in_ready, bus.drop_count, dc0 + 8'd1);
        end
        dc0 = bus.drop_count;
        send(3'd5, 8'h5A, 8'hFF, 1'b1);
        repeat (14) @(negedge clk);
        #1;
        bus.out_ready = 8'h20;
        checks++;
        if (bus.out_valid !== 8'h20) begin
            errors++;
            $display("FAIL timeout_last_hold: ov=%h got, 20 required", bus.out_valid);
        end
        @(negedge clk);
        #1;
        bus.out_ready = 8'h00;
        checks++;
        if (bus.out_valid !== 8'h00 || bus.drop_pulse !== 1'b0 ||
            bus.drop_count !== dc0 || sbq.size() != 0) begin
            errors++;
            $display("FAIL timeout_last_xfer: ov=%h dp=%b dc=%0d pending=%0d got, 0/0/%0d/0 required",
                     bus.out_valid, bus.drop_pulse, bus.drop_count, sbq.size(), dc0);
        end
    endtask

    task automatic test_wrong_ready;
        int n = 0;
        bus.out_ready = 8'hBF;
        send(3'd6, 8'h66, 8'hFF, 1'b0);
        while (bus.out_valid === 8'h40 && n < 300) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n != 15 || bus.drop_pulse !== 1'b1) begin
            errors++;
            $display("FAIL wrong_ready_drop: len=%0d dp=%b got, 15/1 required",
                     n, bus.drop_pulse);
        end
        send(3'd6, 8'h6C, 8'hFF, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 8'h40) begin
            errors++;
            $display("FAIL wrong_ready_c4: ov=%h got, 40 required", bus.out_valid);
        end
        bus.out_ready = 8'hFF;
        @(negedge clk);
        #1;
        bus.out_ready = 8'h00;
        checks++;
        if (bus.out_valid !== 8'h00 || bus.drop_pulse !== 1'b0 ||
            sbq.size() != 0) begin
            errors++;
            $display("FAIL wrong_ready_xfer: ov=%h dp=%b pending=%0d got, 0/0/0 required",
                     bus.out_valid, bus.drop_pulse, sbq.size());
        end
    endtask

    task automatic test_saturation;
        int p0;
        p0 = drops_seen;
        for (int i = 0; i < 260; i++) begin
            send(3'($urandom_range(0, 7)), 8'($urandom), 8'h00, 1'b0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.drop_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_count: dc=%0d got, 255 required", bus.drop_count);
        end
        checks++;
        if (drops_seen - p0 != 260) begin
            errors++;
            $display("FAIL sat_pulses: %0d pulses got, 260 required", drops_seen - p0);
        end
    endtask

    task automatic test_reset_mid_hold;
        int p0;
        bus.out_ready = 8'h00;
        send(3'd1, 8'h11, 8'hFF, 1'b0);
        p0 = drops_seen;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data, bus.sel,
             bus.drop_pulse, bus.drop_count, bus.busy} !== 30'h0) begin
            errors++;
            $display("FAIL midhold_reset: rdy=%b ov=%h od=%h sel=%0d dp=%b dc=%0d busy=%b got, all 0 required",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.sel,
                     bus.drop_pulse, bus.drop_count, bus.busy);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midhold_ready: in_ready=%b got, 1 required", bus.in_ready);
        end
        repeat (2) @(negedge clk);
        #4;
        checks++;
        if (drops_seen != p0 || bus.drop_count !== 8'd0) begin
            errors++;
            $display("FAIL midhold_nodrop: pulses=%0d dc=%0d got, 0/0 required",
                     drops_seen - p0, bus.drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_disabled();
        test_timeout();
        test_wrong_ready();
        test_saturation();
        test_reset_mid_hold();
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d pending got, 0 required", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
